// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard input queue: register map, status/control
// bit positions and the address-decoder region code.
package kbd_pkg;

    localparam logic [11:0] KBD_REGION = 12'h003;

    typedef enum logic [1:0] {
        KBD_DATA   = 2'd0,
        KBD_STATUS = 2'd1,
        KBD_COUNT  = 2'd2,
        KBD_CTRL   = 2'd3
    } kbd_reg_e;

    // STATUS register bit positions
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UNF   = 3;

    // CTRL register bit positions
    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/kbd_fifo_ram.sv
// Queue storage: DEPTH x DATA_W array with one synchronous write port and a
// combinational read port addressed by the read pointer.
module kbd_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; occupancy is tracked by
    // the count, so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kbd_fifo_ctrl.sv
// Keyboard input queue with CPU register interface: hardware-owned pointers,
// occupancy count, sticky overflow/underflow flags, flush and level IRQ.
module kbd_fifo_ctrl
    import kbd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cpu_sel,
    input  logic [1:0]        cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    output logic              irq
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic              ovf;
    logic              unf;
    logic              irq_en;
    logic [DATA_W-1:0] head;

    logic              rd_acc;
    logic              ctrl_wr;
    logic              flush;
    logic              clr;
    logic              pop_req;
    logic              pop_ok;
    logic              push_ok;
    logic              ovf_set;
    logic              unf_set;
    logic [31:0]       rd_value;
    logic              unused_wdata;

    assign unused_wdata = ^cpu_wdata[7:3];

    assign empty = (cnt == '0);
    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign count = cnt;

    assign rd_acc  = cpu_sel & cpu_rd;
    assign ctrl_wr = cpu_sel & cpu_we & (kbd_reg_e'(cpu_addr) == KBD_CTRL);
    assign flush   = ctrl_wr & cpu_wdata[CTRL_FLUSH];
    assign clr     = ctrl_wr & cpu_wdata[CTRL_CLR];
    assign pop_req = rd_acc & (kbd_reg_e'(cpu_addr) == KBD_DATA);

    // Flush overrides both sides; a pop from a full queue makes room for a same-cycle push.
    assign pop_ok  = pop_req & ~empty & ~flush;
    assign push_ok = wr_en & (~full | pop_ok) & ~flush;
    assign ovf_set = wr_en & full & ~pop_ok & ~flush;
    assign unf_set = pop_req & empty & ~flush;

    kbd_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_value = '0;
        case (kbd_reg_e'(cpu_addr))
            KBD_DATA: begin
                if (pop_ok) begin
                    rd_value[DATA_W-1:0] = head;
                end
            end
            KBD_STATUS: begin
                rd_value[ST_EMPTY] = empty;
                rd_value[ST_FULL]  = full;
                rd_value[ST_OVF]   = ovf;
                rd_value[ST_UNF]   = unf;
            end
            KBD_COUNT: rd_value[PTR_W:0] = cnt;
            KBD_CTRL:  rd_value[CTRL_IRQ_EN] = irq_en;
            default:   rd_value = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf    <= 1'b0;
            unf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            ovf <= (ovf & ~clr) | ovf_set;
            unf <= (unf & ~clr) | unf_set;
            if (ctrl_wr) begin
                irq_en <= cpu_wdata[CTRL_IRQ_EN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (rd_acc) begin
                cpu_rdata <= rd_value;
            end
            irq <= irq_en & ~empty;
        end
    end

endmodule
